usb_bit_stuffer: RTL and testbench

Transmit-side USB bit stuffer and serializer. It accepts packet bytes over a valid/ready handshake and shifts them out LSB first, one bit per clock. After every run of STUFF_LEN consecutive 1s on the serial output it inserts a 0 and flags that bit. It sits between the packet/CRC generator and the NRZI encoder, and its serial stream is the exact inverse of what the receive-side bit unstuffer removes.

---
 rtl/usb_bit_stuffer.sv | 137 +++++++++++++
 tb/tb_usb_bit_stuffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bit_stuffer.sv
// Transmit-side USB bit stuffer: serializes packet bytes LSB first and inserts a
// flagged 0 after every STUFF_LEN consecutive 1s on the serial stream.
module usb_bit_stuffer #(
    parameter int STUFF_LEN = 6
) (
    input  logic       Bit_Stuffer_Clk,
    input  logic       Bit_Stuffer_Rst,
    input  logic [7:0] Bit_Stuffer_Data_In,
    input  logic       Bit_Stuffer_Data_Valid,
    input  logic       Bit_Stuffer_Data_Last,
    output logic       Bit_Stuffer_Data_Ready,
    output logic       Bit_Stuffer_Data_Out,
    output logic       Bit_Stuffer_Bit_Valid,
    output logic       Bit_Stuffer_Flag,
    output logic       Bit_Stuffer_Eop_Done,
    output logic       Bit_Stuffer_Underrun
);

    localparam int CW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t        state_reg;
    logic [7:0]    shift_reg;
    logic [2:0]    index_reg;
    logic [CW-1:0] ones_reg;
    logic          last_reg;
    logic          byte_end_reg;      // stuffed 0 in progress follows bit 7
    logic          eop_pend_reg;
    logic          underrun_pend_reg;

    logic          data_out_reg;
    logic          bit_valid_reg;
    logic          flag_reg;
    logic          eop_done_reg;
    logic          underrun_reg;

    logic          cur_bit;
    logic [CW-1:0] ones_next;
    logic          stuff_due;
    logic          byte_end;
    logic          ready;

    assign cur_bit   = shift_reg[index_reg];
    assign ones_next = cur_bit ? (ones_reg + CW'(1)) : '0;
    assign stuff_due = (state_reg == SHIFT) && cur_bit && (ones_reg == CW'(STUFF_LEN - 1));

    // Final emitted bit of a byte: bit 7 without a following stuff, or that stuff
    assign byte_end = ((state_reg == SHIFT) && (index_reg == 3'd7) && !stuff_due) ||
                      ((state_reg == STUFF) && byte_end_reg);

    // Decoded purely from registers, so there is no Valid-to-Ready path
    assign ready = (state_reg == IDLE) || (byte_end && !last_reg);

    always_ff @(posedge Bit_Stuffer_Clk) begin
        if (Bit_Stuffer_Rst) begin
            state_reg         <= IDLE;
            shift_reg         <= '0;
            index_reg         <= '0;
            ones_reg          <= '0;
            last_reg          <= 1'b0;
            byte_end_reg      <= 1'b0;
            eop_pend_reg      <= 1'b0;
            underrun_pend_reg <= 1'b0;
            data_out_reg      <= 1'b0;
            bit_valid_reg     <= 1'b0;
            flag_reg          <= 1'b0;
            eop_done_reg      <= 1'b0;
            underrun_reg      <= 1'b0;
        end else begin
            // Output stage: presents the bit chosen by the current state
            data_out_reg      <= (state_reg == SHIFT) ? cur_bit : 1'b0;
            bit_valid_reg     <= (state_reg != IDLE);
            flag_reg          <= (state_reg == STUFF);
            eop_done_reg      <= eop_pend_reg;
            underrun_reg      <= underrun_pend_reg;
            eop_pend_reg      <= 1'b0;
            underrun_pend_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (Bit_Stuffer_Data_Valid) begin
                        shift_reg    <= Bit_Stuffer_Data_In;
                        index_reg    <= '0;
                        last_reg     <= Bit_Stuffer_Data_Last;
                        byte_end_reg <= 1'b0;
                        ones_reg     <= '0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    ones_reg  <= ones_next;
                    index_reg <= index_reg + 3'd1;
                    if (stuff_due) begin
                        state_reg    <= STUFF;
                        byte_end_reg <= (index_reg == 3'd7);
                    end
                end
                STUFF: begin
                    ones_reg  <= '0;
                    state_reg <= SHIFT;
                end
                default: state_reg <= IDLE;
            endcase

            // End-of-byte action overrides the per-state updates above;
            // the ones counter is left alone so runs carry into the next byte
            if (byte_end) begin
                if (last_reg) begin
                    state_reg    <= IDLE;
                    eop_pend_reg <= 1'b1;
                end else if (Bit_Stuffer_Data_Valid) begin
                    shift_reg    <= Bit_Stuffer_Data_In;
                    index_reg    <= '0;
                    last_reg     <= Bit_Stuffer_Data_Last;
                    byte_end_reg <= 1'b0;
                    state_reg    <= SHIFT;
                end else begin
                    state_reg         <= IDLE;
                    underrun_pend_reg <= 1'b1;
                end
            end
        end
    end

    assign Bit_Stuffer_Data_Ready = ready;
    assign Bit_Stuffer_Data_Out   = data_out_reg;
    assign Bit_Stuffer_Bit_Valid  = bit_valid_reg;
    assign Bit_Stuffer_Flag       = flag_reg;
    assign Bit_Stuffer_Eop_Done   = eop_done_reg;
    assign Bit_Stuffer_Underrun   = underrun_reg;

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Bench for usb_bit_stuffer: directed scenarios plus random packets compared
// against a symbol-stream reference model (bits, stuffed bits, EOP, underrun).
module tb_usb_bit_stuffer;

    localparam int STUFF_LEN = 6;
    localparam int SYM_STUFF = 2;
    localparam int SYM_EOP   = 4;
    localparam int SYM_UND   = 5;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic       ready, dout, bv, flag, eop, und;

    int  n_vec = 0;
    int  n_bad = 0;
    int  exp_q[$];
    int  obs_q[$];
    bit  mon_en = 1'b0;
    logic prev_bv = 1'b0;

    always #5 clk = ~clk;

    usb_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) dut (
        .Bit_Stuffer_Clk        (clk),
        .Bit_Stuffer_Rst        (rst),
        .Bit_Stuffer_Data_In    (din),
        .Bit_Stuffer_Data_Valid (valid),
        .Bit_Stuffer_Data_Last  (last),
        .Bit_Stuffer_Data_Ready (ready),
        .Bit_Stuffer_Data_Out   (dout),
        .Bit_Stuffer_Bit_Valid  (bv),
        .Bit_Stuffer_Flag       (flag),
        .Bit_Stuffer_Eop_Done   (eop),
        .Bit_Stuffer_Underrun   (und)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Output monitor: records the symbol stream and checks end-pulse placement
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bv)  obs_q.push_back(flag ? (SYM_STUFF + int'(dout)) : int'(dout));
            if (eop) obs_q.push_back(SYM_EOP);
            if (und) obs_q.push_back(SYM_UND);
            if (eop || und) check("eop_und_exclusive", {31'd0, eop & und}, 0);
            if (eop || und || (prev_bv && !bv))
                check("end_pulse_after_last_bit", {31'd0, eop | und}, {31'd0, prev_bv & ~bv});
        end
        prev_bv <= bv;
    end

    // Reference: USB stuffing rule applied to the packet's bit sequence
    function automatic void model_pkt(input byte_q_t bytes, input bit gapped);
        int ones = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            if (gapped) ones = 0;
            for (int b = 0; b < 8; b++) begin
                int v = int'(bytes[i][b]);
                exp_q.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == STUFF_LEN) begin
                    exp_q.push_back(SYM_STUFF);
                    ones = 0;
                end
            end
            if (gapped && i != bytes.size() - 1) exp_q.push_back(SYM_UND);
        end
        exp_q.push_back(SYM_EOP);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic l, output int waits);
        @(negedge clk);
        din = b; last = l; valid = 1'b1;
        waits = 0;
        while (!ready && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (!ready) begin
            check("ready_timeout", {31'd0, ready}, 1);
            valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic wait_underrun();
        int t = 0;
        while (!und && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("underrun_seen", {31'd0, und}, 1);
        check("ready_after_underrun", {31'd0, ready}, 1);
    endtask

    task automatic drain_compare(input string name);
        int t = 0;
        int n;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check({name, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_sym%0d", name, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_pkt(input byte_q_t bytes, input bit gapped, input string name);
        int w;
        model_pkt(bytes, gapped);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (i == bytes.size() - 1), w);
            if (gapped && i != bytes.size() - 1) begin
                drop_valid();
                wait_underrun();
            end
        end
        drop_valid();
        drain_compare(name);
    endtask

    initial begin
        int w;
        byte_q_t pkt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out",  {31'd0, dout},  0);
        check("rst_bit_valid", {31'd0, bv},    0);
        check("rst_flag",      {31'd0, flag},  0);
        check("rst_eop",       {31'd0, eop},   0);
        check("rst_underrun",  {31'd0, und},   0);
        check("rst_ready",     {31'd0, ready}, 1);
        rst = 1'b0;
        mon_en = 1'b1;

        pkt = '{8'hFF};
        run_pkt(pkt, 1'b0, "ff_last");
        pkt = '{8'h3F};
        run_pkt(pkt, 1'b0, "3f_last");

        // Back-to-back bytes; Ready must wait exactly through bits 0..6
        pkt = '{8'hF0, 8'h0F};
        model_pkt(pkt, 1'b0);
        send_byte(8'hF0, 1'b0, w);
        send_byte(8'h0F, 1'b1, w);
        check("ready_on_bit7_wait", w, 7);
        drop_valid();
        drain_compare("f0_0f");

        // Lone non-last byte underruns
        for (int b = 0; b < 8; b++) exp_q.push_back((b % 2 == 0) ? 1 : 0);
        exp_q.push_back(SYM_UND);
        send_byte(8'h55, 1'b0, w);
        drop_valid();
        wait_underrun();
        drain_compare("55_underrun");

        // Ones counter must not carry from one packet into the next
        pkt = '{8'hE0};
        model_pkt(pkt, 1'b0);
        pkt = '{8'h07};
        model_pkt(pkt, 1'b0);
        send_byte(8'hE0, 1'b1, w);
        send_byte(8'h07, 1'b1, w);
        drop_valid();
        drain_compare("counter_isolation");

        // Latency, then reset in the 4th bit cycle
        mon_en = 1'b0;
        send_byte(8'hFF, 1'b1, w);
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
        check("latency_no_bit_yet", {31'd0, bv}, 0);
        @(negedge clk);
        check("latency_bit0_valid", {31'd0, bv}, 1);
        check("latency_bit0_value", {31'd0, dout}, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data_out",  {31'd0, dout},  0);
        check("midrst_bit_valid", {31'd0, bv},    0);
        check("midrst_flag",      {31'd0, flag},  0);
        check("midrst_ready",     {31'd0, ready}, 1);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("midrst_no_end_pulse", {31'd0, eop | und | bv}, 0);
        end
        obs_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        pkt = '{8'h00};
        run_pkt(pkt, 1'b0, "after_rst_00");

        // Random packets, biased toward long runs of 1s
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 4);
            bit gapped = ($urandom_range(0, 3) == 0);
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       pkt.push_back(8'hFF);
                    1:       pkt.push_back(8'(8'hF0 | $urandom_range(0, 15)));
                    default: pkt.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            run_pkt(pkt, gapped, $sformatf("rnd%0d", p));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
